md_unit: RTL and testbench

//  E-stage multiply/divide unit; consumer of the D->E pipeline register outputs (E_RD1/E_RD2/op).

---
 rtl/md_unit.sv | 129 ++++++++++++
 tb/tb_md_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: MULT/MULTU/DIV/DIVU run for a fixed number of cycles into HI/LO, MTHI/MTLO write in one cycle.
// Optional MD_ABORT_EN adds an E_Abort flush input that cancels an in-flight op and suppresses a same-cycle start.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        E_Start,
  input  logic [2:0]  E_MDOp,
  input  logic [31:0] E_RD1,
  input  logic [31:0] E_RD2,
`ifdef MD_ABORT_EN
  input  logic        E_Abort,
`endif
  output logic        E_Busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  state_t      state, state_nxt;
  logic [31:0] cnt;
  logic [63:0] pending;
  logic        pend_wr;
  logic [31:0] hi, lo;

  logic abort;
`ifdef MD_ABORT_EN
  assign abort = E_Abort;
`else
  assign abort = 1'b0;
`endif

  logic accept, is_md, is_mul, done;
  assign accept = E_Start && !abort && (state == IDLE);
  assign is_mul = (E_MDOp == OP_MULT) || (E_MDOp == OP_MULTU);
  assign is_md  = is_mul || (E_MDOp == OP_DIV) || (E_MDOp == OP_DIVU);
  assign done   = (state == BUSY) && !abort && (cnt == 32'd1);

  // Arithmetic: signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
  logic [63:0] prod_s, prod_u, result;
  logic [31:0] div_b, mag_a, mag_b, uq, ur, sq, sr, dq, dr;
  logic        div_zero;

  assign prod_s   = $signed({{32{E_RD1[31]}}, E_RD1}) * $signed({{32{E_RD2[31]}}, E_RD2});
  assign prod_u   = {32'd0, E_RD1} * {32'd0, E_RD2};
  assign div_zero = (E_RD2 == 32'd0);
  assign div_b    = div_zero ? 32'd1 : E_RD2;
  assign mag_a    = E_RD1[31] ? (~E_RD1 + 32'd1) : E_RD1;
  assign mag_b    = div_b[31] ? (~div_b + 32'd1) : div_b;
  assign uq       = mag_a / mag_b;
  assign ur       = mag_a % mag_b;
  assign sq       = (E_RD1[31] ^ div_b[31]) ? (~uq + 32'd1) : uq;
  assign sr       = E_RD1[31] ? (~ur + 32'd1) : ur;
  assign dq       = E_RD1 / div_b;
  assign dr       = E_RD1 % div_b;

  always_comb begin
    result = 64'd0;
    case (E_MDOp)
      OP_MULT:  result = prod_s;
      OP_MULTU: result = prod_u;
      OP_DIV:   result = {sr, sq};
      OP_DIVU:  result = {dr, dq};
      default:  result = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_md) state_nxt = BUSY;
      BUSY:    if (abort || done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    E_Busy = (state == BUSY);
    E_HI   = hi;
    E_LO   = lo;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt     <= 32'd0;
      pending <= 64'd0;
      pend_wr <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (accept) begin
      if (is_md) begin
        pending <= result;
        pend_wr <= !(div_zero && !is_mul);
        cnt     <= is_mul ? 32'(MULT_CYCLES) : 32'(DIV_CYCLES);
      end else if (E_MDOp == OP_MTHI) begin
        hi <= E_RD1;
      end else if (E_MDOp == OP_MTLO) begin
        lo <= E_RD1;
      end
    end else if (state == BUSY) begin
      if (abort) begin
        cnt     <= 32'd0;
        pend_wr <= 1'b0;
      end else begin
        cnt <= cnt - 32'd1;
        if (done && pend_wr) begin
          hi <= pending[63:32];
          lo <= pending[31:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against a plain-arithmetic HI/LO model.
module tb_md_unit;
  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        E_Start;
  logic [2:0]  E_MDOp;
  logic [31:0] E_RD1, E_RD2;
`ifdef MD_ABORT_EN
  logic        E_Abort;
`endif
  logic        E_Busy;
  logic [31:0] E_HI, E_LO;

  md_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .E_Start(E_Start), .E_MDOp(E_MDOp),
    .E_RD1(E_RD1), .E_RD2(E_RD2),
`ifdef MD_ABORT_EN
    .E_Abort(E_Abort),
`endif
    .E_Busy(E_Busy), .E_HI(E_HI), .E_LO(E_LO)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Reference result straight from the arithmetic rules.
  task automatic ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] r, output logic wr);
    int sa, sb;
    longint p;
    sa = a; sb = b; wr = 1'b1; r = 64'd0;
    case (op)
      3'd1: begin p = longint'(sa) * longint'(sb); r = p; end
      3'd2: r = 64'(a) * 64'(b);
      3'd3: if (b == 32'd0) wr = 1'b0;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = {32'd0, 32'h8000_0000};
            else r = {32'(sa % sb), 32'(sa / sb)};
      3'd4: if (b == 32'd0) wr = 1'b0;
            else r = {a % b, a / b};
      default: wr = 1'b0;
    endcase
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue a multi-cycle op; optionally inject a stray start before edge T+junk_at.
  task automatic do_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int junk_at, input logic [2:0] junk_op, input logic [31:0] junk_val);
    logic [63:0] r;
    logic        wr;
    int          n;
    n = (op <= 3'd2) ? MULT_N : DIV_N;
    ref_md(op, a, b, r, wr);
    @(negedge clk);
    E_Start = 1'b1; E_MDOp = op; E_RD1 = a; E_RD2 = b;
    @(posedge clk); #1;
    E_Start = 1'b0;
    chk("busy_rise", 32'(E_Busy), 32'd1);
    for (int i = 1; i < n; i++) begin
      if (i == junk_at) begin
        @(negedge clk);
        E_Start = 1'b1; E_MDOp = junk_op; E_RD1 = junk_val; E_RD2 = $urandom;
      end
      @(posedge clk); #1;
      E_Start = 1'b0;
      chk("busy_hold", 32'(E_Busy), 32'd1);
      chk("hi_stable", E_HI, m_hi);
      chk("lo_stable", E_LO, m_lo);
    end
    @(posedge clk); #1;
    chk("busy_fall", 32'(E_Busy), 32'd0);
    if (wr) begin m_hi = r[63:32]; m_lo = r[31:0]; end
    chk("hi_result", E_HI, m_hi);
    chk("lo_result", E_LO, m_lo);
  endtask

  // Single-cycle start: MTHI/MTLO or an invalid opcode.
  task automatic do_one(input logic [2:0] op, input logic [31:0] a);
    @(negedge clk);
    E_Start = 1'b1; E_MDOp = op; E_RD1 = a; E_RD2 = $urandom;
    @(posedge clk); #1;
    E_Start = 1'b0;
    if (op == 3'd5) m_hi = a;
    if (op == 3'd6) m_lo = a;
    chk("one_busy", 32'(E_Busy), 32'd0);
    chk("one_hi", E_HI, m_hi);
    chk("one_lo", E_LO, m_lo);
  endtask

  initial begin
    reset = 1'b0; E_Start = 1'b0; E_MDOp = 3'd0; E_RD1 = 32'd0; E_RD2 = 32'd0;
`ifdef MD_ABORT_EN
    E_Abort = 1'b0;
`endif
    m_hi = 32'd0; m_lo = 32'd0;
    #2;
    chk("rst_busy", 32'(E_Busy), 32'd0);
    chk("rst_hi", E_HI, 32'd0);
    chk("rst_lo", E_LO, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    do_md(3'd1, 32'hFFFF_FFFF, 32'd2, 0, 3'd0, 32'd0);
    chk("t1_hi", E_HI, 32'hFFFF_FFFF);
    chk("t1_lo", E_LO, 32'hFFFF_FFFE);
    do_md(3'd2, 32'hFFFF_FFFF, 32'd2, 0, 3'd0, 32'd0);
    chk("t2_hi", E_HI, 32'h0000_0001);
    chk("t2_lo", E_LO, 32'hFFFF_FFFE);
    do_md(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 3'd0, 32'd0);
    chk("t3_hi", E_HI, 32'hFFFF_FFFF);
    chk("t3_lo", E_LO, 32'hFFFF_FFFD);
    do_md(3'd4, 32'd7, 32'd2, 0, 3'd0, 32'd0);
    chk("t3u_hi", E_HI, 32'd1);
    chk("t3u_lo", E_LO, 32'd3);
    do_one(3'd5, 32'h1234_5678);
    chk("t4_hi", E_HI, 32'h1234_5678);
    do_md(3'd3, 32'd5, 32'd0, 0, 3'd0, 32'd0);
    chk("t4_dz_hi", E_HI, 32'h1234_5678);
    chk("t4_dz_lo", E_LO, 32'd3);
    do_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 3'd0, 32'd0);
    chk("ovf_hi", E_HI, 32'd0);
    chk("ovf_lo", E_LO, 32'h8000_0000);
    do_md(3'd1, 32'h0001_0003, 32'hFFFF_0007, 2, 3'd6, 32'h0000_AAAA);
    do_one(3'd0, $urandom);
    do_one(3'd7, $urandom);

    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 7)
        do_md(3'($urandom_range(1, 4)), pick_val(), pick_val(),
              ($urandom_range(0, 2) == 0) ? $urandom_range(1, MULT_N - 1) : 0,
              3'($urandom_range(0, 7)), $urandom);
      else if (sel < 9)
        do_one(3'($urandom_range(5, 6)), $urandom);
      else
        do_one(($urandom_range(0, 1) == 0) ? 3'd0 : 3'd7, $urandom);
    end

`ifdef MD_ABORT_EN
    do_one(3'd5, 32'hCAFE_0001);
    do_one(3'd6, 32'hCAFE_0002);
    @(negedge clk);
    E_Start = 1'b1; E_MDOp = 3'd3; E_RD1 = 32'd100; E_RD2 = 32'd7;
    @(posedge clk); #1;
    E_Start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    E_Abort = 1'b1;
    @(posedge clk); #1;
    E_Abort = 1'b0;
    chk("abort_busy", 32'(E_Busy), 32'd0);
    chk("abort_hi", E_HI, m_hi);
    chk("abort_lo", E_LO, m_lo);
    repeat (DIV_N) @(posedge clk);
    #1;
    chk("abort_late_hi", E_HI, m_hi);
    chk("abort_late_lo", E_LO, m_lo);
    // Abort coinciding with the completion edge wins.
    @(negedge clk);
    E_Start = 1'b1; E_MDOp = 3'd1; E_RD1 = 32'd9; E_RD2 = 32'd9;
    @(posedge clk); #1;
    E_Start = 1'b0;
    repeat (MULT_N - 1) @(posedge clk);
    @(negedge clk);
    E_Abort = 1'b1;
    @(posedge clk); #1;
    E_Abort = 1'b0;
    chk("abort_done_busy", 32'(E_Busy), 32'd0);
    chk("abort_done_lo", E_LO, m_lo);
    @(negedge clk);
    E_Abort = 1'b1; E_Start = 1'b1; E_MDOp = 3'd5; E_RD1 = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    E_Abort = 1'b0; E_Start = 1'b0;
    chk("abort_idle_hi", E_HI, m_hi);
    chk("abort_idle_busy", 32'(E_Busy), 32'd0);
`endif

    // Asynchronous reset in the middle of a multiply.
    @(negedge clk);
    E_Start = 1'b1; E_MDOp = 3'd1; E_RD1 = 32'd1234; E_RD2 = 32'd5678;
    @(posedge clk); #1;
    E_Start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("mid_rst_busy", 32'(E_Busy), 32'd0);
    chk("mid_rst_hi", E_HI, 32'd0);
    chk("mid_rst_lo", E_LO, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (MULT_N + 2) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(E_Busy), 32'd0);
    chk("post_rst_hi", E_HI, m_hi);
    chk("post_rst_lo", E_LO, m_lo);
    do_md(3'd2, 32'd3, 32'd4, 0, 3'd0, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
